spi_ram_arbiter: RTL and testbench

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

---
 rtl/spi_ram_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/spi_ram_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
// Shared definitions for the SPI/host RAM arbiter: SPI command encodings,
// the arbiter FSM state type and the requester indices used by rr_arb2.
// No ports; imported with import spi_ram_pkg::*.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int REQ_SPI  = 0;
  localparam int REQ_HOST = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_WAIT,
    ST_RESP
  } arb_state_e;

  // Data commands (01, 11) go through the pending slot; address commands
  // (00, 10) only update a latch.
  function automatic logic isQueuedCmd(input logic [1:0] cmd);
    return cmd[0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. Requester 0 is SPI, requester 1 is the
// host. The pointer remembers who should be favoured next time both request:
// after reset SPI is favoured, and each winner hands priority to the other.
// Ports:
//   clk, rst   clock and async active-high reset
//   req_i      request vector {host, spi}
//   update_i   advance the pointer when a grant is taken this cycle
//   gnt_o      one-hot combinational grant
module rr_arb2 import spi_ram_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic hostPrio_q;

  // Grant SPI unless the host is also requesting and holds priority.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[REQ_SPI] && (!req_i[REQ_HOST] || !hostPrio_q)) begin
      gnt_o[REQ_SPI] = 1'b1;
    end else if (req_i[REQ_HOST]) begin
      gnt_o[REQ_HOST] = 1'b1;
    end
  end

  // The last winner loses the next tie: an SPI win gives the host priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hostPrio_q <= 1'b0;
    end else if (update_i && (gnt_o != 2'b00)) begin
      hostPrio_q <= gnt_o[REQ_SPI];
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
// Shares one single-port RAM between an SPI command stream and a local host.
// SPI words: [9:8] command, [7:0] payload. 00 loads wr_addr, 01 queues a write
// of the payload, 10 loads rd_addr, 11 queues a read. Data commands sit in a
// one-deep pending slot until granted; overflowing strobes set sticky spi_ovf.
// Ports:
//   clk, rst                          clock, async active-high reset
//   spi_rx_data/valid                 incoming SPI words
//   spi_tx_data/valid                 SPI read responses
//   host_req/we/addr/wdata            local requester
//   host_gnt/rdata/rvalid             host grant pulse and read response
//   ram_en/we/addr/din, ram_dout      single-port RAM
//   busy, spi_ovf                     status
// Build option: define SPI_RAM_ARB_AUTOINC_EN to post-increment the SPI
// address used by each SPI access.
module spi_ram_arbiter import spi_ram_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [7:0]        spi_tx_data,
  output logic              spi_tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic [7:0]        host_rdata,
  output logic              host_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              busy,
  output logic              spi_ovf
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic              pend_q, pendRd_q;
  logic [7:0]        pendData_q;
  logic              curSpi_q, curRd_q;
  logic [1:0]        waitCnt_q;
  logic              spiOvf_q;
  logic              ramEn_q, ramWe_q, hostGnt_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic [7:0]        ramDin_q;
  logic [7:0]        txData_q, hostRdata_q;
  logic              txValid_q, hostRvalid_q;

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       spiInFlight, spiAccept, spiDrop, grantSpi, inIdle;
  logic [1:0] gnt;

  // SPI decode. A data command is refused while the slot is full or while an
  // SPI access is still between grant and the return to IDLE.
  always_comb begin
    cmd         = spi_rx_data[9:8];
    payload     = spi_rx_data[7:0];
    inIdle      = (state_q == ST_IDLE);
    spiInFlight = !inIdle && curSpi_q;
    spiAccept   = spi_rx_valid && isQueuedCmd(cmd) && !pend_q && !spiInFlight;
    spiDrop     = spi_rx_valid && isQueuedCmd(cmd) && !spiAccept;
    grantSpi    = inIdle && gnt[REQ_SPI];
  end

  rr_arb2 uArb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({host_req, pend_q}),
    .update_i (inIdle),
    .gnt_o    (gnt)
  );

  // Address latches. An address command in the same cycle as an SPI grant
  // wins over the optional post-increment.
  always_comb begin
    wrAddr_d = wrAddr_q;
    rdAddr_d = rdAddr_q;
`ifdef SPI_RAM_ARB_AUTOINC_EN
    if (grantSpi) begin
      if (pendRd_q) begin
        rdAddr_d = rdAddr_q + ADDR_W'(1);
      end else begin
        wrAddr_d = wrAddr_q + ADDR_W'(1);
      end
    end
`endif
    if (spi_rx_valid && (cmd == CMD_WR_ADDR)) begin
      wrAddr_d = ADDR_W'(payload);
    end
    if (spi_rx_valid && (cmd == CMD_RD_ADDR)) begin
      rdAddr_d = ADDR_W'(payload);
    end
  end

  // Main FSM. Every RAM and response output is registered here; the grant
  // edge (IDLE->ACCESS) captures the winner's address and data, so later
  // address commands never disturb an access already under way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wrAddr_q     <= '0;
      rdAddr_q     <= '0;
      pend_q       <= 1'b0;
      pendRd_q     <= 1'b0;
      pendData_q   <= '0;
      curSpi_q     <= 1'b0;
      curRd_q      <= 1'b0;
      waitCnt_q    <= '0;
      spiOvf_q     <= 1'b0;
      ramEn_q      <= 1'b0;
      ramWe_q      <= 1'b0;
      ramAddr_q    <= '0;
      ramDin_q     <= '0;
      hostGnt_q    <= 1'b0;
      txData_q     <= '0;
      txValid_q    <= 1'b0;
      hostRdata_q  <= '0;
      hostRvalid_q <= 1'b0;
    end else begin
      wrAddr_q     <= wrAddr_d;
      rdAddr_q     <= rdAddr_d;
      ramEn_q      <= 1'b0;
      hostGnt_q    <= 1'b0;
      txValid_q    <= 1'b0;
      hostRvalid_q <= 1'b0;
      if (spiDrop) begin
        spiOvf_q <= 1'b1;
      end
      if (spiAccept) begin
        pend_q     <= 1'b1;
        pendRd_q   <= cmd[1];
        pendData_q <= payload;
      end else if (grantSpi) begin
        pend_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            state_q   <= ST_ACCESS;
            ramEn_q   <= 1'b1;
            curSpi_q  <= gnt[REQ_SPI];
            hostGnt_q <= gnt[REQ_HOST];
            if (gnt[REQ_SPI]) begin
              curRd_q   <= pendRd_q;
              ramWe_q   <= !pendRd_q;
              ramAddr_q <= pendRd_q ? rdAddr_q : wrAddr_q;
              ramDin_q  <= pendData_q;
            end else begin
              curRd_q   <= !host_we;
              ramWe_q   <= host_we;
              ramAddr_q <= host_addr;
              ramDin_q  <= host_wdata;
            end
          end
        end
        ST_ACCESS: begin
          ramWe_q   <= 1'b0;
          waitCnt_q <= '0;
          state_q   <= curRd_q ? ST_RD_WAIT : ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (waitCnt_q == 2'(RD_LAT - 1)) begin
            state_q <= ST_RESP;
            if (curSpi_q) begin
              txData_q  <= ram_dout;
              txValid_q <= 1'b1;
            end else begin
              hostRdata_q  <= ram_dout;
              hostRvalid_q <= 1'b1;
            end
          end else begin
            waitCnt_q <= waitCnt_q + 2'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_tx_data  = txData_q;
  assign spi_tx_valid = txValid_q;
  assign host_gnt     = hostGnt_q;
  assign host_rdata   = hostRdata_q;
  assign host_rvalid  = hostRvalid_q;
  assign ram_en       = ramEn_q;
  assign ram_we       = ramWe_q;
  assign ram_addr     = ramAddr_q;
  assign ram_din      = ramDin_q;
  assign busy         = (state_q != ST_IDLE);
  assign spi_ovf      = spiOvf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter
// Directed bench for spi_ram_arbiter (ADDR_W=8, RD_LAT=1) with a small
// synchronous RAM model. Cycle N is the period after the posedge at which a
// stimulus is driven; outputs are sampled 1 time unit after each posedge.
// The auto-increment scenario adapts its expectations to SPI_RAM_ARB_AUTOINC_EN.
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;
  logic       spi_ovf;

  logic [7:0] mem [256];
  int         ramWriteCount;
  int         checkCount;
  int         failCount;

  spi_ram_arbiter #(.ADDR_W(8), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .busy         (busy),
    .spi_ovf      (spi_ovf)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_dout      = 8'h00;
    ramWriteCount = 0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        ramWriteCount <= ramWriteCount + 1;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  // Hard stop in case a scenario wedges the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one SPI strobe for a single cycle; returns in the following cycle.
  task automatic applyStimulus(input logic [9:0] word);
    spi_rx_data  = word;
    spi_rx_valid = 1'b1;
    waitCycles(1);
    spi_rx_valid = 1'b0;
    spi_rx_data  = 10'h000;
  endtask

  task automatic resetDut();
    #2 rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(1);
  endtask

  initial begin
    logic seen;
    logic sawTx;
    int   gntDelay;
    int   writesBefore;

    checkCount   = 0;
    failCount    = 0;
    rst          = 1'b1;
    spi_rx_data  = 10'h000;
    spi_rx_valid = 1'b0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = 8'h00;
    host_wdata   = 8'h00;
    $display("[TB] starting spi_ram_arbiter bench");
    resetDut();

    // Reset state
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ovf", spi_ovf, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_tx_valid", spi_tx_valid, 0);
    checkOutput("rst_host_gnt", host_gnt, 0);

    // SPI write then read back through the same address
    applyStimulus(10'h005);
    waitCycles(3);
    applyStimulus(10'h1A5);
    waitCycles(1);
    checkOutput("wr_ram_en_n2", ram_en, 1);
    checkOutput("wr_ram_we", ram_we, 1);
    checkOutput("wr_ram_addr", ram_addr, 8'h05);
    checkOutput("wr_ram_din", ram_din, 8'hA5);
    waitCycles(3);
    checkOutput("wr_mem5", mem[5], 8'hA5);
    applyStimulus(10'h205);
    waitCycles(3);
    applyStimulus(10'h300);
    waitCycles(1);
    checkOutput("rd_ram_en_n2", ram_en, 1);
    checkOutput("rd_ram_we", ram_we, 0);
    checkOutput("rd_ram_addr", ram_addr, 8'h05);
    waitCycles(1);
    checkOutput("rd_tx_valid_n3", spi_tx_valid, 0);
    checkOutput("rd_busy_n3", busy, 1);
    waitCycles(1);
    checkOutput("rd_tx_valid_n4", spi_tx_valid, 1);
    checkOutput("rd_tx_data_n4", spi_tx_data, 8'hA5);
    waitCycles(1);
    checkOutput("rd_tx_valid_n5", spi_tx_valid, 0);
    checkOutput("rd_tx_data_hold", spi_tx_data, 8'hA5);
    waitCycles(2);

    // Host read of the same location
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h05;
    waitCycles(1);
    checkOutput("hrd_gnt", host_gnt, 1);
    checkOutput("hrd_ram_addr", ram_addr, 8'h05);
    host_req = 1'b0;
    waitCycles(2);
    checkOutput("hrd_rvalid", host_rvalid, 1);
    checkOutput("hrd_rdata", host_rdata, 8'hA5);
    checkOutput("hrd_no_tx", spi_tx_valid, 0);
    waitCycles(2);

    // Contention right after reset: SPI wins, host follows
    resetDut();
    applyStimulus(10'h300);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h07;
    host_wdata = 8'h3C;
    waitCycles(1);
    checkOutput("rr_spi_first_en", ram_en, 1);
    checkOutput("rr_spi_first_we", ram_we, 0);
    checkOutput("rr_spi_first_gnt", host_gnt, 0);
    seen     = 1'b0;
    sawTx    = 1'b0;
    gntDelay = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      waitCycles(1);
      if (spi_tx_valid) sawTx = 1'b1;
      if (host_gnt) begin
        seen     = 1'b1;
        gntDelay = i;
      end
    end
    checkOutput("rr_host_gnt_seen", seen, 1);
    checkOutput("rr_host_gnt_delay", gntDelay, 4);
    checkOutput("rr_tx_before_gnt", sawTx, 1);
    checkOutput("rr_host_ram_we", ram_we, 1);
    checkOutput("rr_host_ram_addr", ram_addr, 8'h07);
    checkOutput("rr_host_ram_din", ram_din, 8'h3C);
    host_req = 1'b0;
    host_we  = 1'b0;
    waitCycles(2);
    checkOutput("rr_mem7", mem[7], 8'h3C);

    // Overflow: second write strobe while the first is still pending
    writesBefore = ramWriteCount;
    applyStimulus(10'h1FF);
    applyStimulus(10'h1FF);
    waitCycles(5);
    checkOutput("ovf_one_write", ramWriteCount - writesBefore, 1);
    checkOutput("ovf_mem0", mem[0], 8'hFF);
    checkOutput("ovf_flag", spi_ovf, 1);
    waitCycles(3);
    checkOutput("ovf_sticky", spi_ovf, 1);

    // Reset during RD_WAIT aborts the read
    applyStimulus(10'h205);
    applyStimulus(10'h300);
    waitCycles(1);
    checkOutput("abort_ram_addr_pre", ram_addr, 8'h05);
    waitCycles(1);
    checkOutput("abort_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ovf", spi_ovf, 0);
    checkOutput("abort_ram_addr", ram_addr, 0);
    checkOutput("abort_outs", {spi_tx_valid, host_gnt, host_rvalid, ram_en, ram_we,
                               ram_din, spi_tx_data, host_rdata}, 0);
    waitCycles(1);
    rst   = 1'b0;
    sawTx = 1'b0;
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      if (spi_tx_valid || ram_en) sawTx = 1'b1;
    end
    checkOutput("abort_no_resp", sawTx, 0);

    // Address wrap with auto-increment (or fixed address without it)
    applyStimulus(10'h0FF);
    waitCycles(1);
    applyStimulus(10'h111);
    waitCycles(4);
    applyStimulus(10'h122);
    waitCycles(4);
`ifdef SPI_RAM_ARB_AUTOINC_EN
    checkOutput("inc_memFF", mem[255], 8'h11);
    checkOutput("inc_mem00", mem[0], 8'h22);
`else
    checkOutput("noinc_memFF", mem[255], 8'h22);
    checkOutput("noinc_mem00", mem[0], 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
